mult_div: RTL

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div_pkg.sv | 46 ++++
 rtl/mult_div_iter.sv | 64 ++++++
 rtl/mult_div.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared MDOp encodings, control struct and sign helpers for mult_div.
package mult_div_pkg;

  localparam logic [2:0] MD_NOP   = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  localparam int WORD_W = 32;

  // Per-operation attributes captured when an iterative op is accepted.
  typedef struct packed {
    logic is_div;
    logic is_signed;
    logic neg_a;
    logic neg_b;
    logic b_zero;
  } md_ctl_t;

  function automatic logic is_iterative(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // 32'h80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v,
                                                  input logic take_abs);
    return (take_abs && v[WORD_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WORD_W-1:0] negate_if(input logic [WORD_W-1:0] v,
                                                  input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_div_iter.sv
// rtl/mult_div_iter.sv - unsigned iterative datapath: one shift-add multiply or
// restoring shift-subtract divide step per enabled cycle.
module md_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [31:0] hi_step,
  output logic [31:0] lo_step
);

  logic [31:0] acc;
  logic [31:0] quo;
  logic [31:0] mcand;
  logic        div_mode;

  logic [32:0] add_sum;
  logic [32:0] add_sel;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    add_sum = {1'b0, acc} + {1'b0, mcand};
    add_sel = quo[0] ? add_sum : {1'b0, acc};
    rem_sh  = {acc, quo[31]};
    diff    = rem_sh - {1'b0, mcand};
    hi_step = acc;
    lo_step = quo;
    if (div_mode) begin
      // Partial remainder stays below the divisor, so diff[32] is a clean borrow.
      if (!diff[32]) begin
        hi_step = diff[31:0];
        lo_step = {quo[30:0], 1'b1};
      end else begin
        hi_step = rem_sh[31:0];
        lo_step = {quo[30:0], 1'b0};
      end
    end else begin
      hi_step = add_sel[32:1];
      lo_step = {add_sel[0], quo[31:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      quo      <= '0;
      mcand    <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      quo      <= a_mag;
      mcand    <= b_mag;
      div_mode <= is_div;
    end else if (step) begin
      acc <= hi_step;
      quo <= lo_step;
    end
  end

endmodule

// File: rtl/mult_div.sv
// rtl/mult_div.sv - MIPS-style HI/LO multiply/divide unit with a 32-cycle
// iterative core, sign handling around an unsigned datapath.
module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int ITER_COUNT = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        accept;
  logic        step;
  logic        finish;
  logic        wr_hi;
  logic        wr_lo;
  logic        last;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  md_ctl_t     ctl;
  logic [63:0] result;

  assign last = (cnt == 5'(ITER_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_iterative(MDOp)) begin
            accept     = 1'b1;
            state_next = S_RUN;
          end else if (MDOp == MD_MTHI) begin
            wr_hi = 1'b1;
          end else if (MDOp == MD_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operands enter the core as magnitudes; signs are reapplied at the end.
  assign a_mag = magnitude(A, is_signed_op(MDOp));
  assign b_mag = magnitude(B, is_signed_op(MDOp));

  md_iter u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (step),
    .is_div  (is_div_op(MDOp)),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .hi_step (step_hi),
    .lo_step (step_lo)
  );

  always_comb begin
    ctl.is_div    = is_div_op(op_q);
    ctl.is_signed = is_signed_op(op_q);
    ctl.neg_a     = ctl.is_signed & a_q[31];
    ctl.neg_b     = ctl.is_signed & b_q[31];
    ctl.b_zero    = (b_q == '0);
  end

  always_comb begin
    result = {hi_q, lo_q};
    if (ctl.is_div) begin
      // Divide by zero bypasses the core: quotient all ones, remainder = dividend.
      if (ctl.b_zero) begin
        result = {a_q, 32'hFFFF_FFFF};
      end else begin
        result[31:0]  = negate_if(step_lo, ctl.neg_a ^ ctl.neg_b);
        result[63:32] = negate_if(step_hi, ctl.neg_a);
      end
    end else if ((ctl.neg_a ^ ctl.neg_b) == 1'b1) begin
      result = ~{step_hi, step_lo} + 64'd1;
    end else begin
      result = {step_hi, step_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= MD_NOP;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        cnt  <= '0;
        op_q <= MDOp;
        a_q  <= A;
        b_q  <= B;
      end else if (step) begin
        cnt <= cnt + 5'd1;
      end
      if (finish) begin
        hi_q <= result[63:32];
        lo_q <= result[31:0];
      end else begin
        if (wr_hi) hi_q <= A;
        if (wr_lo) lo_q <= A;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
